mem_lsu_stage: RTL and testbench

//  Parametrised MEM pipeline stage between ex_mem and mem_wb. Replaces the single-cycle

---
 rtl/mem_lsu_stage_if.sv | 21 ++
 rtl/mem_lsu_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_lsu_stage.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_stage_if.sv
// Data-bus bundle between the MEM stage (master) and the data memory (slave).
// Latency: none, wires only.
// Backpressure: req is held by the master until gnt; the response comes later on rvalid.
interface mem_lsu_stage_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) ();
    localparam int NBYTES = XLEN / 8;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic [NBYTES-1:0] wmask;
    logic              gnt;
    logic              rvalid;
    logic [XLEN-1:0]   rdata;

    modport master (output req, we, addr, wdata, wmask, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, wmask, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage: req/gnt/rvalid data-bus access with lane alignment, misalign trap, flush/drain.
// Latency: non-mem and misaligned ops 1 cycle; memory ops 1 cycle after the rvalid cycle (min 3).
// Backpressure: stall_o holds upstream from acceptance until the response; held inputs are ignored.
module mem_lsu_stage #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              ren_i,
    input  logic              wen_i,
    input  logic [2:0]        func3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rd_wdata_i,
    input  logic [4:0]        rd_waddr_i,
    input  logic              reg_wen_i,
    input  logic              flush_i,
    mem_lsu_stage_if.master   dbus,
    output logic              stall_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [XLEN-1:0]   rd_wdata_o,
    output logic [4:0]        rd_waddr_o,
    output logic              reg_wen_o,
    output logic              misalign_o
);
    localparam int NBYTES = XLEN / 8;
    localparam int OFF_W  = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t state_q, state_d;

    // In-flight copy of the accepted memory op
    logic [ADDR_W-1:0] addr_q, pc_q;
    logic [OFF_W-1:0]  off_q;
    logic              we_q, dst_wen_q;
    logic [XLEN-1:0]   wdata_q;
    logic [NBYTES-1:0] wmask_q;
    logic [2:0]        func3_q;
    logic [4:0]        dst_q;

    // Registered result towards mem_wb
    logic              res_vld_q, res_vld_d, res_mis_q, res_mis_d, res_wen_q, res_wen_d;
    logic [ADDR_W-1:0] res_pc_q, res_pc_d;
    logic [XLEN-1:0]   res_dat_q, res_dat_d;
    logic [4:0]        res_dst_q, res_dst_d;

    logic              memop, aligned, accept;
    logic [OFF_W-1:0]  off;
    logic [NBYTES-1:0] ones, mask_in;
    logic [XLEN-1:0]   wdata_sh, rdata_sh, load_ext;

    assign memop  = valid_i & (ren_i | wen_i) & ~flush_i;
    assign off    = addr_i[OFF_W-1:0];
    assign accept = (state_q == IDLE) & memop & aligned;

    // Size legality / alignment check and store lane placement for the incoming op
    always_comb begin
        aligned = 1'b0;
        ones    = '1;
        case (func3_i)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~addr_i[0];
            3'b010:         aligned = (addr_i[1:0] == 2'b00);
            3'b110:         aligned = (XLEN == 64) && (addr_i[1:0] == 2'b00);
            3'b011:         aligned = (XLEN == 64) && (addr_i[2:0] == 3'b000);
            default:        aligned = 1'b0;
        endcase
        case (func3_i[1:0])
            2'd0:    ones = NBYTES'(1);
            2'd1:    ones = NBYTES'(3);
            2'd2:    ones = NBYTES'(15);
            default: ones = '1;
        endcase
        mask_in  = ones << off;
        wdata_sh = wdata_i << {off, 3'b000};
    end

    // Load data: move the addressed lane down to bit 0, then sign/zero extend
    always_comb begin
        rdata_sh = dbus.rdata >> {off_q, 3'b000};
        case (func3_q)
            3'b000:  load_ext = XLEN'($signed(rdata_sh[7:0]));
            3'b001:  load_ext = XLEN'($signed(rdata_sh[15:0]));
            3'b010:  load_ext = XLEN'($signed(rdata_sh[31:0]));
            3'b100:  load_ext = XLEN'(rdata_sh[7:0]);
            3'b101:  load_ext = XLEN'(rdata_sh[15:0]);
            3'b110:  load_ext = XLEN'(rdata_sh[31:0]);
            default: load_ext = rdata_sh;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; a flushed op whose response is still owed goes through DRAIN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = REQ;
            REQ:   if (dbus.gnt) state_d = flush_i ? DRAIN : WAIT;
                   else if (flush_i) state_d = IDLE;
            WAIT:  if (flush_i) state_d = dbus.rvalid ? IDLE : DRAIN;
                   else if (dbus.rvalid) state_d = IDLE;
            DRAIN: if (dbus.rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: bus request, stall and the next result word
    always_comb begin
        dbus.req  = (state_q == REQ);
        dbus.we   = we_q;
        dbus.addr = addr_q;
        dbus.wdata = wdata_q;
        dbus.wmask = wmask_q;
        stall_o   = accept | (state_q == REQ) | (state_q == DRAIN) |
                    ((state_q == WAIT) & ~dbus.rvalid & ~flush_i);
        res_vld_d = 1'b0;
        res_mis_d = 1'b0;
        res_wen_d = 1'b0;
        res_pc_d  = '0;
        res_dat_d = '0;
        res_dst_d = '0;
        if (state_q == IDLE && valid_i && !flush_i) begin
            if (!(ren_i | wen_i)) begin
                res_vld_d = 1'b1;
                res_pc_d  = inst_addr_i;
                res_dat_d = rd_wdata_i;
                res_dst_d = rd_waddr_i;
                res_wen_d = reg_wen_i;
            end else if (!aligned) begin
                res_vld_d = 1'b1;
                res_mis_d = 1'b1;
                res_pc_d  = inst_addr_i;
                res_dst_d = rd_waddr_i;
            end
        end else if (state_q == WAIT && dbus.rvalid && !flush_i) begin
            res_vld_d = 1'b1;
            res_pc_d  = pc_q;
            res_dst_d = dst_q;
            res_wen_d = dst_wen_q & ~we_q;
            res_dat_d = we_q ? '0 : load_ext;
        end
    end

    // Capture the accepted op; stays stable for the whole bus transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0; off_q <= '0; we_q <= 1'b0; wdata_q <= '0; wmask_q <= '0;
            func3_q <= '0; dst_q <= '0; dst_wen_q <= 1'b0; pc_q <= '0;
        end else if (accept) begin
            addr_q    <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            off_q     <= off;
            we_q      <= wen_i;
            wdata_q   <= wen_i ? wdata_sh : '0;
            wmask_q   <= wen_i ? mask_in : '0;
            func3_q   <= func3_i;
            dst_q     <= rd_waddr_i;
            dst_wen_q <= reg_wen_i;
            pc_q      <= inst_addr_i;
        end
    end

    // Result register: valid is a single-cycle pulse, payload holds until the next result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_vld_q <= 1'b0; res_mis_q <= 1'b0; res_wen_q <= 1'b0;
            res_pc_q <= '0; res_dat_q <= '0; res_dst_q <= '0;
        end else begin
            res_vld_q <= res_vld_d;
            if (res_vld_d) begin
                res_mis_q <= res_mis_d;
                res_wen_q <= res_wen_d;
                res_pc_q  <= res_pc_d;
                res_dat_q <= res_dat_d;
                res_dst_q <= res_dst_d;
            end
        end
    end

    assign valid_o     = res_vld_q;
    assign misalign_o  = res_mis_q;
    assign reg_wen_o   = res_wen_q;
    assign inst_addr_o = res_pc_q;
    assign rd_wdata_o  = res_dat_q;
    assign rd_waddr_o  = res_dst_q;
endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage: 64-bit instance with a hand-driven bus, 32-bit instance for illegal sizes.
// Latency: checks the 1-cycle and req/gnt/rvalid result timing.
// Backpressure: checks stall_o and held requests under delayed gnt/rvalid.
module tb_mem_lsu_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ren_i, wen_i, reg_wen_i, flush_i, v32_i;
    logic [63:0] inst_addr_i, addr_i, wdata_i, rd_wdata_i;
    logic [2:0]  func3_i;
    logic [4:0]  rd_waddr_i;

    logic        stall_o, valid_o, reg_wen_o, misalign_o;
    logic [63:0] inst_addr_o, rd_wdata_o;
    logic [4:0]  rd_waddr_o;

    logic        s32_stall, s32_valid, s32_wen, s32_mis;
    logic [63:0] s32_pc;
    logic [31:0] s32_dat;
    logic [4:0]  s32_dst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_lsu_stage_if #(.XLEN(64), .ADDR_W(64)) bus ();
    mem_lsu_stage_if #(.XLEN(32), .ADDR_W(64)) bus32 ();

    mem_lsu_stage #(.XLEN(64), .ADDR_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .inst_addr_i(inst_addr_i),
        .ren_i(ren_i), .wen_i(wen_i), .func3_i(func3_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rd_wdata_i(rd_wdata_i), .rd_waddr_i(rd_waddr_i),
        .reg_wen_i(reg_wen_i), .flush_i(flush_i), .dbus(bus.master),
        .stall_o(stall_o), .valid_o(valid_o), .inst_addr_o(inst_addr_o),
        .rd_wdata_o(rd_wdata_o), .rd_waddr_o(rd_waddr_o), .reg_wen_o(reg_wen_o),
        .misalign_o(misalign_o)
    );

    mem_lsu_stage #(.XLEN(32), .ADDR_W(64)) dut32 (
        .clk(clk), .rst_n(rst_n), .valid_i(v32_i), .inst_addr_i(inst_addr_i),
        .ren_i(ren_i), .wen_i(wen_i), .func3_i(func3_i), .addr_i(addr_i),
        .wdata_i(wdata_i[31:0]), .rd_wdata_i(rd_wdata_i[31:0]), .rd_waddr_i(rd_waddr_i),
        .reg_wen_i(reg_wen_i), .flush_i(flush_i), .dbus(bus32.master),
        .stall_o(s32_stall), .valid_o(s32_valid), .inst_addr_o(s32_pc),
        .rd_wdata_o(s32_dat), .rd_waddr_o(s32_dst), .reg_wen_o(s32_wen),
        .misalign_o(s32_mis)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; v32_i = 1'b0; ren_i = 1'b0; wen_i = 1'b0; flush_i = 1'b0;
        func3_i = 3'b000; addr_i = '0; wdata_i = '0; rd_wdata_i = '0;
        rd_waddr_i = '0; reg_wen_i = 1'b0; inst_addr_i = '0;
    endtask

    task automatic present(input logic st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        valid_i = 1'b1; ren_i = ~st; wen_i = st; func3_i = f3; addr_i = a; wdata_i = wd;
        rd_wdata_i = 64'h5A5A; rd_waddr_i = 5'd9; reg_wen_i = 1'b1; inst_addr_i = 64'h400;
    endtask

    // One aligned memory op through the bus: gnt after gdly wait cycles, rvalid rdly cycles after gnt
    task automatic mem_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rdw,
                          input int gdly, input int rdly, input logic [63:0] exp_dat,
                          input logic [63:0] exp_mask, input logic [63:0] exp_wd, input logic exp_wen);
        int req_cyc = 0;
        step();
        present(st, f3, a, wd);
        #1;
        check_eq({tag, "_acc_stall"}, stall_o, 1);
        check_eq({tag, "_acc_noreq"}, bus.req, 0);
        step();
        check_eq({tag, "_addr"}, bus.addr, a & ~64'h7);
        check_eq({tag, "_we"}, bus.we, st);
        check_eq({tag, "_mask"}, bus.wmask, exp_mask);
        if (st) check_eq({tag, "_wdata"}, bus.wdata, exp_wd);
        for (int i = 0; i < gdly; i++) begin
            if (bus.req) req_cyc++;
            check_eq({tag, "_req_stall"}, stall_o, 1);
            step();
        end
        if (bus.req) req_cyc++;
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        check_eq({tag, "_req_cycles"}, req_cyc, gdly + 1);
        for (int i = 0; i < rdly - 1; i++) begin
            check_eq({tag, "_wait_stall"}, stall_o, 1);
            check_eq({tag, "_wait_noreq"}, bus.req, 0);
            check_eq({tag, "_wait_novld"}, valid_o, 0);
            step();
        end
        bus.rvalid = 1'b1;
        bus.rdata  = rdw;
        #1;
        check_eq({tag, "_rv_stall"}, stall_o, 0);
        valid_i = 1'b0;
        step();
        bus.rvalid = 1'b0;
        check_eq({tag, "_vld"}, valid_o, 1);
        check_eq({tag, "_mis"}, misalign_o, 0);
        check_eq({tag, "_regwen"}, reg_wen_o, exp_wen);
        check_eq({tag, "_dst"}, rd_waddr_o, 9);
        check_eq({tag, "_pc"}, inst_addr_o, 64'h400);
        if (!st) check_eq({tag, "_rdata"}, rd_wdata_o, exp_dat);
        step();
        check_eq({tag, "_pulse"}, valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        bus32.gnt = 1'b0; bus32.rvalid = 1'b0; bus32.rdata = '0;
        #12;
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_req", bus.req, 0);
        check_eq("rst_stall", stall_o, 0);
        check_eq("rst_mask", bus.wmask, 0);
        check_eq("rst_rdata", rd_wdata_o, 0);
        step();
        rst_n = 1'b1;

        // Non-memory op: one registered cycle
        step();
        valid_i = 1'b1; rd_wdata_i = 64'h1234; rd_waddr_i = 5'd1; reg_wen_i = 1'b1; inst_addr_i = 64'h200;
        #1;
        check_eq("alu_stall", stall_o, 0);
        step();
        valid_i = 1'b0;
        check_eq("alu_vld", valid_o, 1);
        check_eq("alu_data", rd_wdata_o, 64'h1234);
        check_eq("alu_dst", rd_waddr_o, 1);
        check_eq("alu_wen", reg_wen_o, 1);
        check_eq("alu_pc", inst_addr_o, 64'h200);
        step();
        check_eq("alu_pulse", valid_o, 0);

        // Non-memory op killed by flush
        valid_i = 1'b1; flush_i = 1'b1;
        step();
        idle_inputs();
        check_eq("alu_flush_novld", valid_o, 0);

        // Loads: lane selection and extension, with various bus delays
        mem_op("lb3", 1'b0, 3'b000, 64'h1003, 0, 64'h8877665544332211, 0, 1,
               64'h0000000000000044, 0, 0, 1'b1);
        mem_op("lb7", 1'b0, 3'b000, 64'h1007, 0, 64'h8877665544332211, 1, 1,
               64'hFFFFFFFFFFFFFF88, 0, 0, 1'b1);
        mem_op("lhu6", 1'b0, 3'b101, 64'h1006, 0, 64'h8877665544332211, 3, 2,
               64'h0000000000008877, 0, 0, 1'b1);
        mem_op("lh2", 1'b0, 3'b001, 64'h1002, 0, 64'h8877665544332211, 0, 3,
               64'h0000000000004433, 0, 0, 1'b1);
        mem_op("lw4", 1'b0, 3'b010, 64'h1004, 0, 64'h8877665544332211, 2, 1,
               64'hFFFFFFFF88776655, 0, 0, 1'b1);
        mem_op("lwu4", 1'b0, 3'b110, 64'h1004, 0, 64'h8877665544332211, 0, 1,
               64'h0000000088776655, 0, 0, 1'b1);
        mem_op("lbu7", 1'b0, 3'b100, 64'h1007, 0, 64'h8877665544332211, 0, 1,
               64'h0000000000000088, 0, 0, 1'b1);
        mem_op("ld0", 1'b0, 3'b011, 64'h1000, 0, 64'h8877665544332211, 0, 1,
               64'h8877665544332211, 0, 0, 1'b1);

        // Stores: byte enables and lane shift, no register write
        mem_op("sh6", 1'b1, 3'b001, 64'h1006, 64'hBEEF, 0, 0, 1, 0,
               64'hC0, 64'hBEEF000000000000, 1'b0);
        mem_op("sw4", 1'b1, 3'b010, 64'h1004, 64'hDEADBEEF, 0, 1, 2, 0,
               64'hF0, 64'hDEADBEEF00000000, 1'b0);
        mem_op("sb1", 1'b1, 3'b000, 64'h1001, 64'hAB, 0, 0, 1, 0,
               64'h02, 64'h000000000000AB00, 1'b0);
        mem_op("sd0", 1'b1, 3'b011, 64'h1000, 64'h0123456789ABCDEF, 0, 0, 1, 0,
               64'hFF, 64'h0123456789ABCDEF, 1'b0);

        // Misaligned load: no request, trap result next cycle
        step();
        present(1'b0, 3'b010, 64'h1002, 0);
        #1;
        check_eq("mis_stall", stall_o, 0);
        check_eq("mis_noreq", bus.req, 0);
        step();
        valid_i = 1'b0;
        check_eq("mis_vld", valid_o, 1);
        check_eq("mis_flag", misalign_o, 1);
        check_eq("mis_wen", reg_wen_o, 0);
        check_eq("mis_noreq2", bus.req, 0);
        step();
        check_eq("mis_pulse", valid_o, 0);

        // Doubleword on the 32-bit instance is an illegal size
        idle_inputs();
        v32_i = 1'b1; ren_i = 1'b1; func3_i = 3'b011; addr_i = 64'h1000; reg_wen_i = 1'b1; rd_waddr_i = 5'd4;
        #1;
        check_eq("x32_ld_stall", s32_stall, 0);
        check_eq("x32_ld_noreq", bus32.req, 0);
        step();
        v32_i = 1'b0;
        check_eq("x32_ld_vld", s32_valid, 1);
        check_eq("x32_ld_mis", s32_mis, 1);
        check_eq("x32_ld_wen", s32_wen, 0);
        check_eq("x32_ld_noreq2", bus32.req, 0);
        // WU is illegal there as well
        v32_i = 1'b1; func3_i = 3'b110; addr_i = 64'h1004;
        step();
        v32_i = 1'b0;
        check_eq("x32_lwu_mis", s32_mis, 1);
        idle_inputs();

        // Flush in REQ before gnt: back to IDLE, no result
        step();
        present(1'b0, 3'b000, 64'h1003, 0);
        step();
        check_eq("fl_req", bus.req, 1);
        flush_i = 1'b1; valid_i = 1'b0;
        #1;
        check_eq("fl_req_stall", stall_o, 1);
        step();
        flush_i = 1'b0;
        check_eq("fl_req_idle", bus.req, 0);
        check_eq("fl_req_nostall", stall_o, 0);
        check_eq("fl_req_novld", valid_o, 0);
        step();
        check_eq("fl_req_novld2", valid_o, 0);

        // Flush together with gnt: DRAIN swallows the response, later flush ignored
        present(1'b0, 3'b000, 64'h1003, 0);
        step();
        bus.gnt = 1'b1; flush_i = 1'b1; valid_i = 1'b0;
        step();
        bus.gnt = 1'b0; flush_i = 1'b0;
        check_eq("fl_gnt_drain_stall", stall_o, 1);
        check_eq("fl_gnt_noreq", bus.req, 0);
        step();
        flush_i = 1'b1;
        #1;
        check_eq("fl_drain_flush_ign", stall_o, 1);
        flush_i = 1'b0;
        bus.rvalid = 1'b1; bus.rdata = 64'hFFFF;
        #1;
        check_eq("fl_drain_rv_stall", stall_o, 1);
        step();
        bus.rvalid = 1'b0;
        check_eq("fl_drain_novld", valid_o, 0);
        check_eq("fl_drain_idle", stall_o, 0);
        step();
        check_eq("fl_drain_novld2", valid_o, 0);

        // Flush in WAIT on the rvalid cycle: response discarded
        present(1'b0, 3'b011, 64'h1000, 0);
        step();
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0; valid_i = 1'b0;
        bus.rvalid = 1'b1; bus.rdata = 64'h77; flush_i = 1'b1;
        #1;
        check_eq("fl_wait_nostall", stall_o, 0);
        step();
        bus.rvalid = 1'b0; flush_i = 1'b0;
        check_eq("fl_wait_novld", valid_o, 0);

        // Load to leave a nonzero result, then reset in the middle of the next op's WAIT
        mem_op("ldpre", 1'b0, 3'b011, 64'h1000, 0, 64'h1122334455667788, 0, 1,
               64'h1122334455667788, 0, 0, 1'b1);
        present(1'b0, 3'b011, 64'h1000, 0);
        step();
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        check_eq("rstw_stall_pre", stall_o, 1);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_eq("rstw_req", bus.req, 0);
        check_eq("rstw_stall", stall_o, 0);
        check_eq("rstw_vld", valid_o, 0);
        check_eq("rstw_rdata", rd_wdata_o, 0);
        check_eq("rstw_wen", reg_wen_o, 0);
        step();
        rst_n = 1'b1;

        // add x1,x2 right after reset
        step();
        valid_i = 1'b1; rd_wdata_i = 64'h3; rd_waddr_i = 5'd1; reg_wen_i = 1'b1;
        #1;
        check_eq("add_stall", stall_o, 0);
        step();
        valid_i = 1'b0;
        check_eq("add_vld", valid_o, 1);
        check_eq("add_data", rd_wdata_o, 64'h3);
        check_eq("add_dst", rd_waddr_o, 1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
